internet_scheduler: RTL and testbench
=====================================

// Module: internet_scheduler
// PURPOSE
//  Upstream stage of the 4-way internet demux: time-slot arbiter for Lib/FD/School/Ribs.
//  - Arbitrates 4 destination requests round-robin; one grant at a time.
//  - Drives the demux's muxOutput/Enable/Sel with a registered source nibble.
//  - Each grant lasts up to SLOT_CYCLES clocks; a 1-cycle dead gap follows every slot.
// PARAMETERS
//  WIDTH        4   data width forwarded to demux (muxOutput)
//  SLOT_CYCLES  8   max clocks per grant; legal range 1..255
//  CNT_W        8   slot counter width; must satisfy 2**CNT_W > SLOT_CYCLES
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  reset      in   1      synchronous, active-high
//  req        in   4      [0]=Lib [1]=FD [2]=School [3]=Ribs; level, held while wanting service
//  data_in    in   WIDTH  source data to forward to granted destination
//  muxOutput  out  WIDTH  registered data to demux; 0 when not Enable
//  Enable     out  1      high during an active slot
//  Sel        out  2      index of granted destination (00 Lib .. 11 Ribs)
//  grant      out  4      one-hot copy of Sel when Enable, else 0000
//  busy       out  1      high in SERVE or GAP
// BEHAVIOUR
//  Reset (synchronous, active-high):
//  - state=IDLE, ptr=0, cnt=0, muxOutput=0, Enable=0, Sel=00, grant=0000, busy=0.
//  - Reset wins over everything; an active slot is aborted and outputs read 0 on the next cycle.
//  States:
//  - IDLE: if |req, pick the first set bit scanning ptr, ptr+1, .. (mod 4).
//    Next cycle enter SERVE with Sel=idx, Enable=1, grant=1<<idx, cnt=SLOT_CYCLES-1.
//  - SERVE: slot ends at the edge where cnt==0 OR req[Sel]==0 (early release).
//    At slot end: ptr<=Sel+1 (3 wraps to 0), go to GAP. Otherwise cnt<=cnt-1.
//  - GAP: exactly one cycle; Enable=0, grant=0, muxOutput=0, Sel holds last value.
//    Arbitrates exactly as IDLE. Goes to SERVE if |req, else IDLE.
//  Latency and timing:
//  - req rising in IDLE at edge N -> Enable=1 after edge N.
//  - muxOutput<=data_in on every edge whose next state is SERVE; else muxOutput<=0.
//  - So data appears 1 clock after sampling.
//  - Slot length with req held = SLOT_CYCLES cycles.
//  - Back-to-back service = SLOT_CYCLES + 1 cycle period.
//  Boundary cases:
//  - SLOT_CYCLES=1: every slot is 1 cycle.
//  - Lone requester held: re-granted after each GAP; ptr wraps, so it re-wins.
//  - All four held: grants strictly 0,1,2,3,0,...
//  - req changes mid-slot for other indices: ignored until next arbitration.
//  Invariants:
//  - grant is always one-hot or zero.
//  - Enable==|grant.
//  - Never two grants in consecutive cycles to different Sel without a GAP.
// CONFIGURATION
//  INTERNET_SCHED_STATS_EN
//  - Defined: adds port grant_cnt out 32, four 8-bit fields [8i+7:8i] for destination i.
//  - Each field increments on entering SERVE for that destination.
//  - Fields saturate at 255 and clear on reset.
//  - Undefined: port and counters absent; all other behaviour identical.
// TESTING
//  1. reset held 3 clks with req=1111 -> Enable=0, grant=0000, muxOutput=0 throughout; busy=0.
//  2. SLOT_CYCLES=4, req=0010 held, data_in=A -> Enable 4 cycles, Sel=01, muxOutput=A,
//     GAP 1 cycle, then re-grant FD.
//  3. req=1111 held -> grant order 0001,0010,0100,1000,0001 each 4 cycles with 1-cycle gaps.
//  4. req=0100 grant, drop req[2] after 2 cycles -> slot ends at that edge, GAP, IDLE; ptr=3.
//  5. Assert reset mid-SERVE -> next cycle all outputs 0, state IDLE; next req=0001 grants Lib.
//  6. With STATS_EN: Ribs granted 300 times -> grant_cnt[31:24]=255 (saturated), others 0.

Source files
------------

// File: rtl/internet_scheduler.sv
// internet_scheduler
//   Time-slot arbiter in front of the 4-way internet demux (Lib/FD/School/Ribs).
//   Round-robin over four level requests, one grant at a time. Each slot runs
//   for up to SLOT_CYCLES clocks and is followed by a one-cycle dead gap.
//   All outputs are registered.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   req[3:0]   [0]=Lib [1]=FD [2]=School [3]=Ribs, held while wanting service
//   data_in    source data forwarded to the granted destination
//   muxOutput  registered data to demux, 0 outside a slot
//   Enable     high during an active slot
//   Sel        granted destination index (holds through GAP/IDLE)
//   grant      one-hot of Sel while Enable, else 0
//   busy       high in SERVE or GAP
//   grant_cnt  (INTERNET_SCHED_STATS_EN only) four saturating 8-bit grant
//              counters, field [8i+7:8i] for destination i
//
// Build option: define INTERNET_SCHED_STATS_EN to add grant_cnt.
module internet_scheduler #(
  parameter int WIDTH       = 4,
  parameter int SLOT_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] muxOutput,
  output logic             Enable,
  output logic [1:0]       Sel,
  output logic [3:0]       grant,
`ifdef INTERNET_SCHED_STATS_EN
  output logic [31:0]      grant_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  // Round-robin pick: first set bit scanning ptr, ptr+1, ... (mod 4).
  // Walk offsets high to low so the smallest offset is the last to write.
  logic       arb_hit;
  logic [1:0] arb_idx;
  always_comb begin
    logic [1:0] idx;
    arb_hit = 1'b0;
    arb_idx = ptr;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        arb_hit = 1'b1;
        arb_idx = idx;
      end
    end
  end

  // Slot ends on terminal count or when the granted requester lets go.
  logic slot_end;
  assign slot_end = (cnt == '0) || !req[Sel];

`ifdef INTERNET_SCHED_STATS_EN
  logic [3:0][7:0] stat_q;
  assign grant_cnt = stat_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      muxOutput <= '0;
      Enable    <= 1'b0;
      Sel       <= 2'd0;
      grant     <= 4'b0000;
      busy      <= 1'b0;
`ifdef INTERNET_SCHED_STATS_EN
      stat_q    <= '0;
`endif
    end else begin
      case (state)
        SERVE: begin
          if (slot_end) begin
            state     <= GAP;
            ptr       <= Sel + 2'd1;  // natural 2-bit wrap 3 -> 0
            muxOutput <= '0;
            Enable    <= 1'b0;
            grant     <= 4'b0000;
            busy      <= 1'b1;
          end else begin
            cnt       <= cnt - 1'b1;
            muxOutput <= data_in;
            busy      <= 1'b1;
          end
        end
        default: begin  // IDLE and GAP arbitrate identically
          if (arb_hit) begin
            state     <= SERVE;
            Sel       <= arb_idx;
            cnt       <= CNT_W'(SLOT_CYCLES - 1);
            muxOutput <= data_in;
            Enable    <= 1'b1;
            grant     <= 4'b0001 << arb_idx;
            busy      <= 1'b1;
`ifdef INTERNET_SCHED_STATS_EN
            if (stat_q[arb_idx] != 8'hFF)
              stat_q[arb_idx] <= stat_q[arb_idx] + 8'd1;
`endif
          end else begin
            state     <= IDLE;
            muxOutput <= '0;
            Enable    <= 1'b0;
            grant     <= 4'b0000;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_internet_scheduler.sv
module tb_internet_scheduler;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] muxOutput;
  logic             Enable;
  logic [1:0]       Sel;
  logic [3:0]       grant;
  logic             busy;
`ifdef INTERNET_SCHED_STATS_EN
  logic [31:0]      grant_cnt;
`endif

  internet_scheduler #(.WIDTH(WIDTH), .SLOT_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .muxOutput (muxOutput),
    .Enable    (Enable),
    .Sel       (Sel),
    .grant     (grant),
`ifdef INTERNET_SCHED_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             en;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic [WIDTH-1:0] mux;
    logic             busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // One clock of stimulus plus the outputs expected right after that edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [WIDTH-1:0] d,
                      input logic en, input logic [1:0] sel,
                      input logic [WIDTH-1:0] mux, input logic bsy);
    exp_t e;
    @(negedge clk);
    reset   = r;
    req     = rq;
    data_in = d;
    e.en    = en;
    e.sel   = sel;
    e.grant = en ? (4'b0001 << sel) : 4'b0000;
    e.mux   = mux;
    e.busy  = bsy;
    q.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is checked 1 time unit later.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = '{en: Enable, sel: Sel, grant: grant, mux: muxOutput, busy: busy};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got en=%b sel=%0d grant=%b mux=%h busy=%b, want en=%b sel=%0d grant=%b mux=%h busy=%b",
                   $time, a.en, a.sel, a.grant, a.mux, a.busy,
                   e.en, e.sel, e.grant, e.mux, e.busy);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req = 4'b1111; data_in = '0;

    // Reset held 3 clocks with all requests up: everything stays 0.
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 4'h9, 0, 0, 4'h0, 0);

    // Lone FD requester: 4-cycle slot with per-cycle data, GAP, re-grant, early release.
    step(0, 4'b0010, 4'hA, 1, 1, 4'hA, 1);
    step(0, 4'b0010, 4'hB, 1, 1, 4'hB, 1);
    step(0, 4'b0010, 4'hC, 1, 1, 4'hC, 1);
    step(0, 4'b0010, 4'hD, 1, 1, 4'hD, 1);
    step(0, 4'b0010, 4'h5, 0, 1, 4'h0, 1);  // GAP, Sel holds
    step(0, 4'b0010, 4'h6, 1, 1, 4'h6, 1);  // re-grant FD after wrap
    step(0, 4'b0000, 4'h7, 0, 1, 4'h0, 1);  // release -> GAP
    step(0, 4'b0000, 4'h7, 0, 1, 4'h0, 0);  // IDLE

    // All four held from ptr=0: 0,1,2,3,0 with one-cycle gaps.
    step(1, 4'b0000, 4'h0, 0, 0, 4'h0, 0);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++)
        step(0, 4'b1111, 4'(g*4 + c), 1, 2'(g % 4), 4'(g*4 + c), 1);
      step(0, 4'b1111, 4'hF, 0, 2'(g % 4), 4'h0, 1);
    end
    step(0, 4'b0000, 4'h0, 0, 0, 4'h0, 0);  // ptr now 1

    // School: other req bits toggling mid-slot are ignored; drop req[2] after 2 cycles.
    step(0, 4'b0100, 4'h1, 1, 2, 4'h1, 1);
    step(0, 4'b1101, 4'h2, 1, 2, 4'h2, 1);
    step(0, 4'b0000, 4'h3, 0, 2, 4'h0, 1);
    step(0, 4'b0000, 4'h3, 0, 2, 4'h0, 0);
    // ptr must be 3 now: with everything requesting, Ribs wins.
    step(0, 4'b1111, 4'h4, 1, 3, 4'h4, 1);
    step(0, 4'b1111, 4'h5, 1, 3, 4'h5, 1);

    // Reset mid-SERVE aborts the slot; Lib then wins from ptr=0.
    step(1, 4'b1111, 4'h6, 0, 0, 4'h0, 0);
    step(0, 4'b0001, 4'h7, 1, 0, 4'h7, 1);
    step(0, 4'b0001, 4'h8, 1, 0, 4'h8, 1);
    step(0, 4'b0000, 4'h9, 0, 0, 4'h0, 1);
    step(0, 4'b0000, 4'h9, 0, 0, 4'h0, 0);

`ifdef INTERNET_SCHED_STATS_EN
    // 300 Ribs grants: its field saturates, the others stay 0.
    step(1, 4'b0000, 4'h0, 0, 0, 4'h0, 0);
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 4; c++) step(0, 4'b1000, 4'h1, 1, 3, 4'h1, 1);
      step(0, 4'b1000, 4'h2, 0, 3, 4'h0, 1);
    end
    step(0, 4'b0000, 4'h0, 0, 3, 4'h0, 0);
    @(negedge clk);
    checks++;
    if (grant_cnt !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL grant_cnt: got %h want ff000000", grant_cnt);
    end
`endif

    // Drain: every expectation must have been consumed within a few clocks.
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
